// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: fetches the word at the PC, latches the IR, steps the PC,
// then resolves JMP/JZ, stops on HALT, or hands the IR to execute.
module fetch_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int OPC_W  = 3,
  parameter logic [OPC_W-1:0] OPC_JZ   = 3'b101,
  parameter logic [OPC_W-1:0] OPC_JMP  = 3'b110,
  parameter logic [OPC_W-1:0] OPC_HALT = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              zero_flag,
  input  logic              exec_done,
  output logic              ld_pc,
  output logic              inc_pc,
  output logic [ADDR_W-1:0] pc_target,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  output logic              halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_INCR   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [OPC_W-1:0] opc;
  logic             is_jump;

  assign opc     = ir_out[DATA_W-1 -: OPC_W];
  // JZ with zero_flag clear falls through: the PC was already stepped in INCR.
  assign is_jump = (opc == OPC_JMP) || ((opc == OPC_JZ) && zero_flag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ir_out <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && mem_ack)
        ir_out <= mem_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (mem_ack) state_nxt = S_INCR;
      S_INCR:   state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_jump || opc == OPC_JZ) state_nxt = S_FETCH;
        else if (opc == OPC_HALT)     state_nxt = S_HALT;
        else                          state_nxt = S_EXEC;
      end
      S_EXEC:   if (exec_done) state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign mem_rd    = (state == S_FETCH);
  assign mem_addr  = mem_rd ? pc_addr : '0;
  assign inc_pc    = (state == S_INCR);
  assign ld_pc     = (state == S_DECODE) && is_jump;
  assign ir_valid  = (state == S_EXEC);
  assign halted    = (state == S_HALT);
  assign pc_target = ir_out[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: instruction-level model compared every cycle, plus directed literal checks.
module tb_fetch_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_addr;
  logic          mem_rd, mem_ack = 1'b0, zero_flag = 1'b0, exec_done = 1'b0;
  logic [AW-1:0] mem_addr, pc_target;
  logic [DW-1:0] mem_data = '0, ir_out;
  logic          ld_pc, inc_pc, ir_valid, halted;

  int n_chk = 0;
  int n_fail = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .zero_flag(zero_flag), .exec_done(exec_done),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .pc_target(pc_target),
    .ir_out(ir_out), .ir_valid(ir_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  // Model: where we are in the life of one instruction, the IR it holds, and the program counter.
  typedef enum int {P_IDLE, P_READ, P_STEP, P_RESOLVE, P_RUN, P_STOP} phase_t;
  phase_t        ph = P_IDLE;
  logic [DW-1:0] m_ir = '0;
  logic [AW-1:0] m_pc = '0;

  assign pc_addr = m_pc;

  function automatic bit jump_taken(input logic [DW-1:0] ir, input logic zf);
    return (ir[7:5] == 3'b110) || (ir[7:5] == 3'b101 && zf);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ph <= P_IDLE; m_ir <= '0; m_pc <= '0;
    end else begin
      case (ph)
        P_IDLE:  ph <= P_READ;
        P_READ:  if (mem_ack) begin m_ir <= mem_data; ph <= P_STEP; end
        P_STEP:  begin m_pc <= m_pc + 1'b1; ph <= P_RESOLVE; end
        P_RESOLVE: begin
          if (jump_taken(m_ir, zero_flag)) begin m_pc <= m_ir[AW-1:0]; ph <= P_READ; end
          else if (m_ir[7:5] == 3'b101)    ph <= P_READ;
          else if (m_ir[7:5] == 3'b111)    ph <= P_STOP;
          else                             ph <= P_RUN;
        end
        P_RUN:   if (exec_done) ph <= P_READ;
        default: ph <= ph;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if ($time > 6) begin
      chk("m_mem_rd",    32'(mem_rd),    32'(ph == P_READ));
      chk("m_mem_addr",  32'(mem_addr),  (ph == P_READ) ? 32'(m_pc) : 32'd0);
      chk("m_inc_pc",    32'(inc_pc),    32'(ph == P_STEP));
      chk("m_ld_pc",     32'(ld_pc),     32'(ph == P_RESOLVE && jump_taken(m_ir, zero_flag)));
      chk("m_ir_out",    32'(ir_out),    32'(m_ir));
      chk("m_pc_target", 32'(pc_target), 32'(m_ir[AW-1:0]));
      chk("m_ir_valid",  32'(ir_valid),  32'(ph == P_RUN));
      chk("m_halted",    32'(halted),    32'(ph == P_STOP));
      chk("m_no_both",   32'(ld_pc & inc_pc), 32'd0);
    end
  end

  task automatic nxt(); @(posedge clk); #2; endtask
  task automatic smp(); @(negedge clk); endtask

  // Entered just after the edge that put the DUT in FETCH; leaves it just after entering DECODE.
  task automatic fetch(input logic [DW-1:0] data, input int delay, input logic [AW-1:0] addr);
    for (int i = 0; i < delay; i++) begin
      mem_ack = 1'b0; smp(); chk("rd_wait", 32'(mem_rd), 32'd1); nxt();
    end
    mem_ack = 1'b1; mem_data = data;
    smp(); chk("rd_addr", 32'(mem_addr), 32'(addr)); chk("rd_high", 32'(mem_rd), 32'd1);
    nxt(); mem_ack = 1'b0;
    smp(); chk("incr_pulse", 32'(inc_pc), 32'd1); chk("ir_latched", 32'(ir_out), 32'(data));
    nxt();
  endtask

  initial begin
    // 1: reset two cycles, then one IDLE cycle
    nxt(); nxt(); reset = 1'b0;
    smp(); chk("t1_idle_rd", 32'(mem_rd), 32'd0); chk("t1_ir", 32'(ir_out), 32'd0);
    chk("t1_target", 32'(pc_target), 32'd0);
    nxt();
    // 2: ordinary instruction with one-cycle execute
    fetch(8'h23, 0, 5'd0);
    smp(); chk("t2_no_ld", 32'(ld_pc), 32'd0); chk("t2_no_valid", 32'(ir_valid), 32'd0);
    nxt(); exec_done = 1'b1;
    smp(); chk("t2_valid", 32'(ir_valid), 32'd1);
    nxt(); exec_done = 1'b0;
    // 3: JMP 18
    fetch(8'hD2, 0, 5'd1);
    smp(); chk("t3_ld", 32'(ld_pc), 32'd1); chk("t3_target", 32'(pc_target), 32'd18);
    chk("t3_no_valid", 32'(ir_valid), 32'd0);
    nxt();
    // 4a: JZ 10 not taken
    fetch(8'hAA, 0, 5'd18);
    smp(); chk("t4a_no_ld", 32'(ld_pc), 32'd0);
    nxt();
    // 4b: JZ 10 taken
    fetch(8'hAA, 0, 5'd19);
    zero_flag = 1'b1;
    smp(); chk("t4b_ld", 32'(ld_pc), 32'd1); chk("t4b_target", 32'(pc_target), 32'd10);
    nxt(); zero_flag = 1'b0;
    smp(); chk("t4b_addr", 32'(mem_addr), 32'd10);
    // 6a: reset while a read is pending; an ack on the reset edge must not load the IR
    nxt(); reset = 1'b1; mem_ack = 1'b1; mem_data = 8'h55;
    nxt(); reset = 1'b0; mem_ack = 1'b0;
    smp(); chk("t6a_rd_low", 32'(mem_rd), 32'd0); chk("t6a_ir", 32'(ir_out), 32'd0);
    nxt();
    fetch(8'h23, 0, 5'd0);
    nxt();
    // 6b: reset during EXEC
    smp(); chk("t6b_valid", 32'(ir_valid), 32'd1);
    reset = 1'b1;
    nxt(); reset = 1'b0;
    smp(); chk("t6b_valid_low", 32'(ir_valid), 32'd0); chk("t6b_ir", 32'(ir_out), 32'd0);
    chk("t6b_rd_low", 32'(mem_rd), 32'd0);
    nxt();
    // 5: delayed ack, then HALT sticks
    fetch(8'hE0, 3, 5'd0);
    smp(); chk("t5_no_ld", 32'(ld_pc), 32'd0);
    nxt();
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1; exec_done = 1'b1; mem_data = 8'h23;
      smp(); chk("t5_halted", 32'(halted), 32'd1); chk("t5_ir", 32'(ir_out), 32'hE0);
      chk("t5_rd_low", 32'(mem_rd), 32'd0);
      nxt();
    end
    mem_ack = 1'b0; exec_done = 1'b0;
    smp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
